// File: rtl/stack_unit_pkg.sv
// stack_unit_pkg: shared types for the loop/return stack (BYTE data, STACK_OP opcodes)
package stack_unit_pkg;
  typedef logic [7:0] BYTE;
  typedef enum logic [1:0] {STACK_NOP, STACK_PUSH, STACK_POP, STACK_REPLACE} STACK_OP;
endpackage

// File: rtl/stack_unit_if.sv
// stack_unit_if: control-side bundle (stall/op/clear/push_data in; top-of-stack, count, empty/full, sticky errors out)
interface stack_unit_if #(parameter int DEPTH = 16, parameter int WIDTH = 8);
  import stack_unit_pkg::*;
  logic stall;
  STACK_OP stack_op;
  logic stack_clear;
  logic [WIDTH-1:0] push_data;
  logic [WIDTH-1:0] stack_out;
  logic [$clog2(DEPTH+1)-1:0] stack_count;
  logic stack_empty;
  logic stack_full;
  logic overflow_err;
  logic underflow_err;
  modport master (
    output stall, stack_op, stack_clear, push_data,
    input stack_out, stack_count, stack_empty, stack_full, overflow_err, underflow_err
  );
  modport slave (
    input stall, stack_op, stack_clear, push_data,
    output stack_out, stack_count, stack_empty, stack_full, overflow_err, underflow_err
  );
endinterface

// File: rtl/stack_unit.sv
// stack_unit: DEPTH x WIDTH hardware loop stack; clk/reset plus stack_unit_if.slave carrying ops, top-of-stack, status and sticky errors
module stack_unit
  import stack_unit_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic reset,
  stack_unit_if.slave s
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0] sp;
  logic [AW-1:0] top_idx;
  logic ovf, unf, empty, full, act, do_push, do_pop, do_repl, ovf_set, unf_set;
  assign top_idx = AW'(sp - CW'(1));
  assign empty = sp == '0;
  assign full = sp == CW'(DEPTH);
  always_comb begin
    act = !s.stall && !s.stack_clear;
    do_push = act && s.stack_op == STACK_PUSH && !full;
    do_pop = act && s.stack_op == STACK_POP && !empty;
    do_repl = act && s.stack_op == STACK_REPLACE && !empty;
    ovf_set = act && s.stack_op == STACK_PUSH && full;
    unf_set = act && (s.stack_op == STACK_POP || s.stack_op == STACK_REPLACE) && empty;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sp <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (!s.stall && s.stack_clear) begin
      sp <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      sp <= do_push ? sp + CW'(1) : do_pop ? sp - CW'(1) : sp;
      ovf <= ovf | ovf_set;
      unf <= unf | unf_set;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset && (do_push || do_repl))
      mem[do_push ? sp[AW-1:0] : top_idx] <= s.push_data;
  end
  assign s.stack_out = empty ? '0 : mem[top_idx];
  assign s.stack_count = sp;
  assign s.stack_empty = empty;
  assign s.stack_full = full;
  assign s.overflow_err = ovf;
  assign s.underflow_err = unf;
endmodule

// File: tb/tb_stack_unit.sv
// tb_stack_unit: directed self-checking bench for stack_unit
module tb_stack_unit;
  import stack_unit_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  stack_unit_if #(.DEPTH(16), .WIDTH(8)) s ();
  stack_unit #(.DEPTH(16), .WIDTH(8)) dut (.clk(clk), .reset(reset), .s(s));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step(input STACK_OP op, input logic [7:0] d);
    s.stack_op = op;
    s.push_data = d;
    @(posedge clk);
    #1;
    s.stack_op = STACK_NOP;
  endtask
  task automatic status(input string tag, input logic [7:0] o, input logic [4:0] c,
                        input logic e, input logic f, input logic ov, input logic un);
    chk({tag, "_out"}, 32'(s.stack_out), 32'(o));
    chk({tag, "_count"}, 32'(s.stack_count), 32'(c));
    chk({tag, "_empty"}, 32'(s.stack_empty), 32'(e));
    chk({tag, "_full"}, 32'(s.stack_full), 32'(f));
    chk({tag, "_ovf"}, 32'(s.overflow_err), 32'(ov));
    chk({tag, "_unf"}, 32'(s.underflow_err), 32'(un));
  endtask
  initial begin
    s.stall = 1'b0;
    s.stack_op = STACK_NOP;
    s.stack_clear = 1'b0;
    s.push_data = 8'h00;
    step(STACK_NOP, 8'h00);
    step(STACK_NOP, 8'h00);
    reset = 1'b0;
    step(STACK_NOP, 8'h00);
    status("reset_idle", 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(STACK_PUSH, 8'h11);
    status("push11", 8'h11, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(STACK_PUSH, 8'h22);
    chk("push22_out", 32'(s.stack_out), 32'h22);
    step(STACK_PUSH, 8'h33);
    status("push33", 8'h33, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    step(STACK_POP, 8'h00);
    status("pop_to22", 8'h22, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0);
    s.stack_clear = 1'b1;
    step(STACK_NOP, 8'h00);
    s.stack_clear = 1'b0;
    status("clear1", 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) step(STACK_PUSH, 8'(i));
    status("fill16", 8'h0F, 5'd16, 1'b0, 1'b1, 1'b0, 1'b0);
    step(STACK_PUSH, 8'hFF);
    status("overflow", 8'h0F, 5'd16, 1'b0, 1'b1, 1'b1, 1'b0);
    step(STACK_POP, 8'h00);
    status("pop_after_ovf", 8'h0E, 5'd15, 1'b0, 1'b0, 1'b1, 1'b0);
    s.stack_clear = 1'b1;
    step(STACK_NOP, 8'h00);
    s.stack_clear = 1'b0;
    status("clear2", 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(STACK_POP, 8'h00);
    status("underflow_pop", 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(STACK_REPLACE, 8'hAA);
    status("underflow_repl", 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
    step(STACK_PUSH, 8'h55);
    status("push55_sticky", 8'h55, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1);
    s.stack_clear = 1'b1;
    step(STACK_NOP, 8'h00);
    s.stack_clear = 1'b0;
    step(STACK_PUSH, 8'h10);
    chk("push10_out", 32'(s.stack_out), 32'h10);
    step(STACK_REPLACE, 8'hA2);
    status("replace_a2", 8'hA2, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    s.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(STACK_POP, 8'h00);
      chk("stall_pop_count", 32'(s.stack_count), 32'd1);
      chk("stall_pop_out", 32'(s.stack_out), 32'hA2);
    end
    s.stack_clear = 1'b1;
    step(STACK_PUSH, 8'h77);
    s.stack_clear = 1'b0;
    status("stall_clear", 8'hA2, 5'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    s.stall = 1'b0;
    step(STACK_POP, 8'h00);
    status("unstall_pop", 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(STACK_POP, 8'h00);
    for (int i = 1; i <= 4; i++) step(STACK_PUSH, 8'(i));
    status("four_with_err", 8'h04, 5'd4, 1'b0, 1'b0, 1'b0, 1'b1);
    s.stack_clear = 1'b1;
    step(STACK_PUSH, 8'h99);
    s.stack_clear = 1'b0;
    status("clear_beats_push", 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(STACK_PUSH, 8'h07);
    step(STACK_PUSH, 8'h08);
    chk("pre_reset_out", 32'(s.stack_out), 32'h08);
    reset = 1'b1;
    step(STACK_PUSH, 8'h09);
    reset = 1'b0;
    status("reset_beats_push", 8'h00, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
